e_mdu_ctrl: RTL and testbench
=============================

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU/MADD/MADDU.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 E_mdu_op  in  4  op code: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10.
REQ-006 E_mdu_valid  in  1  qualifies E_mdu_op; low means treat the op as NONE.
REQ-007 E_rs_data  in  32  operand A (dividend, multiplicand, MTHI/MTLO source).
REQ-008 E_rt_data  in  32  operand B (divisor, multiplier).
REQ-009 E_HL_data  out  32  HI for MFHI, LO for MFLO, else 0; combinational from committed HI/LO.
REQ-010 E_mdu_busy  out  1  registered; high while a mult/div is in flight.
REQ-011 E_mdu_start  out  1  combinational; high in the cycle a mult/div/madd op is accepted.
REQ-012 E_mdu_stall  out  1  combinational; E_mdu_start | E_mdu_busy, consumed by the hazard unit.

Function
REQ-013 States: IDLE, MUL, DIV; 5-bit down-counter cnt; committed regs HI, LO; pending regs HI_p, LO_p.
REQ-014 In IDLE, a valid MULT/MULTU/MADD/MADDU moves to MUL, loads cnt=MULT_CYCLES, and computes HI_p/LO_p from the operands sampled that cycle.
REQ-015 In IDLE, a valid DIV/DIVU moves to DIV, loads cnt=DIV_CYCLES, and sets HI_p=remainder, LO_p=quotient.
REQ-016 MULT/DIV are signed; MULTU/DIVU are unsigned; the 64-bit product splits {HI_p,LO_p}; signed remainder takes the sign of the dividend.
REQ-017 In MUL/DIV, cnt decrements each cycle; when cnt==1, HI/LO <= HI_p/LO_p and the state returns to IDLE in the same edge.
REQ-018 E_mdu_busy is high for exactly MULT_CYCLES (DIV_CYCLES) cycles after the accepting edge, and is low in the cycle the new HI/LO become visible.
REQ-019 Divisor 0: the DIV sequence runs its full latency, and HI/LO keep their prior values at commit.
REQ-020 MTHI/MTLO in IDLE write HI/LO at the next edge with no busy cycles; MFHI/MFLO read committed HI/LO in the same cycle.
REQ-021 Any op presented while busy (stall contract violated) is ignored; state, cnt, HI_p/LO_p unchanged.
REQ-022 MFHI/MFLO while busy return the old committed values; the hazard unit prevents this use.
REQ-023 NONE or E_mdu_valid=0 has no effect in any state.

Reset
REQ-024 reset has priority over every op: state=IDLE, cnt=0, HI=LO=HI_p=LO_p=0, E_mdu_busy=0.
REQ-025 Reset mid-operation aborts the op with no commit; the first edge after reset deasserts may accept a new op.

Configuration
REQ-026 Macro MDU_MADD_EN: when defined, MADD/MADDU set {HI_p,LO_p} = {HI,LO} + signed/unsigned product (64-bit wrap) and take the MUL path.
REQ-027 When MDU_MADD_EN is undefined, op codes 9/10 are treated as NONE: no start, no stall, no state change.

Structure
REQ-028 Op-code constants and state encodings SHALL live in the shared CPU define package, also used by the decoder and hazard unit.
REQ-029 The datapath SHALL be one sub-module, mdu_arith: combinational 64-bit multiply/divide producing HI_p/LO_p next values.
REQ-030 The FSM, counter and HI/LO registers SHALL remain in e_mdu_ctrl.

Verification
REQ-031 MULT rs=0xFFFFFFFF, rt=2 -> start=1 for one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 DIVU rs=100, rt=7 -> busy=1 for 10 cycles, then LO=14, HI=2; DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 MTHI 0x1234 then MFHI next cycle -> E_HL_data=0x1234, busy never asserted; DIV by 0 -> HI/LO unchanged after 10 cycles.
REQ-034 MULT issued, reset pulsed at busy cycle 3 -> HI=LO=0, busy=0 next cycle; a MULTU 3*4 issued right after -> LO=12 five cycles later.
REQ-035 MULT during DIV busy -> ignored; the DIV result commits unchanged at cycle 10.
REQ-036 With MDU_MADD_EN, HI:LO=0:0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0; without the macro, the same op -> stall=0 and HI/LO unchanged.

Source files
------------

// File: rtl/e_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_ctrl_pkg
// Description : Shared CPU define package for the multiply/divide unit. Holds
//               the E-stage MDU op-code constants (also used by the decoder
//               and hazard unit), the MDU FSM state encodings and the counter
//               width.
// Config      : op codes 9/10 (MADD/MADDU) only take effect when MDU_MADD_EN
//               is defined in the consuming modules.
// Revision    : 1.0 - initial release
// ============================================================================
package e_mdu_ctrl_pkg;

   // MDU op codes carried on E_mdu_op
   localparam logic [3:0] c_op_none  = 4'd0;
   localparam logic [3:0] c_op_mult  = 4'd1;
   localparam logic [3:0] c_op_multu = 4'd2;
   localparam logic [3:0] c_op_div   = 4'd3;
   localparam logic [3:0] c_op_divu  = 4'd4;
   localparam logic [3:0] c_op_mfhi  = 4'd5;
   localparam logic [3:0] c_op_mflo  = 4'd6;
   localparam logic [3:0] c_op_mthi  = 4'd7;
   localparam logic [3:0] c_op_mtlo  = 4'd8;
   localparam logic [3:0] c_op_madd  = 4'd9;
   localparam logic [3:0] c_op_maddu = 4'd10;

   // MDU FSM state encodings
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_mul  = 2'd1;
   localparam logic [1:0] c_st_div  = 2'd2;

   // Latency down-counter width
   localparam int c_cnt_w = 5;

endpackage : e_mdu_ctrl_pkg
`default_nettype wire

// File: rtl/e_mdu_ctrl_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational 64-bit multiply / divide datapath. Produces the
//               pending HI/LO values for the op presented this cycle.
// Ports       : i_op       - MDU op code (already valid-qualified)
//               i_rs, i_rt - operand A / operand B
//               i_hi, i_lo - committed HI/LO (accumulator for MADD, and the
//                            hold value for divide-by-zero)
//               o_hi_nxt   - next pending HI (product high / remainder)
//               o_lo_nxt   - next pending LO (product low / quotient)
// Config      : MDU_MADD_EN - adds MADD/MADDU accumulate into {HI,LO}.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
   import e_mdu_ctrl_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [31:0] o_hi_nxt,
   output logic [31:0] o_lo_nxt
);

   logic signed [63:0] w_rs_s64;
   logic signed [63:0] w_rt_s64;
   logic        [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic        [31:0] w_rt_safe;
   logic signed [31:0] w_quo_s;
   logic signed [31:0] w_rem_s;
   logic        [31:0] w_quo_u;
   logic        [31:0] w_rem_u;
   logic               w_div_zero;

   assign w_rs_s64 = {{32{i_rs[31]}}, i_rs};
   assign w_rt_s64 = {{32{i_rt[31]}}, i_rt};
   assign w_prod_s = w_rs_s64 * w_rt_s64;
   assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

   // The divider never sees a zero divisor; the zero case is handled by
   // holding HI/LO, so the substituted divisor value is irrelevant.
   assign w_div_zero = (i_rt == 32'd0);
   assign w_rt_safe  = w_div_zero ? 32'd1 : i_rt;

   // Signed division truncates toward zero, so the remainder follows the
   // dividend's sign.
   assign w_quo_s = $signed(i_rs) / $signed(w_rt_safe);
   assign w_rem_s = $signed(i_rs) % $signed(w_rt_safe);
   assign w_quo_u = i_rs / w_rt_safe;
   assign w_rem_u = i_rs % w_rt_safe;

   always_comb begin
      o_hi_nxt = i_hi;
      o_lo_nxt = i_lo;
      case (i_op)
         c_op_mult:  {o_hi_nxt, o_lo_nxt} = w_prod_s;
         c_op_multu: {o_hi_nxt, o_lo_nxt} = w_prod_u;
         c_op_div: begin
            if (!w_div_zero) begin
               o_hi_nxt = w_rem_s;
               o_lo_nxt = w_quo_s;
            end
         end
         c_op_divu: begin
            if (!w_div_zero) begin
               o_hi_nxt = w_rem_u;
               o_lo_nxt = w_quo_u;
            end
         end
`ifdef MDU_MADD_EN
         c_op_madd:  {o_hi_nxt, o_lo_nxt} = {i_hi, i_lo} + w_prod_s;
         c_op_maddu: {o_hi_nxt, o_lo_nxt} = {i_hi, i_lo} + w_prod_u;
`endif
         default: begin
            o_hi_nxt = i_hi;
            o_lo_nxt = i_lo;
         end
      endcase
   end

endmodule : mdu_arith
`default_nettype wire

// File: rtl/e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu_ctrl
// Description : E-stage multiply/divide unit controller. Accepts MDU ops in
//               IDLE, runs a fixed-latency busy window for mult/div, and
//               commits the pending HI/LO when the latency counter expires.
// Ports       : clk          - sole clock, rising edge
//               reset        - synchronous active-high reset
//               E_mdu_op     - MDU op code
//               E_mdu_valid  - qualifies E_mdu_op
//               E_rs_data    - operand A
//               E_rt_data    - operand B
//               E_HL_data    - HI (MFHI) / LO (MFLO) / 0, combinational
//               E_mdu_busy   - registered, mult/div in flight
//               E_mdu_start  - combinational, mult/div accepted this cycle
//               E_mdu_stall  - E_mdu_start | E_mdu_busy
// Config      : MDU_MADD_EN - enables MADD/MADDU; otherwise ops 9/10 are NONE.
// Revision    : 1.0 - initial release
// ============================================================================
module e_mdu_ctrl
   import e_mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_mdu_op,
   input  logic        E_mdu_valid,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   output logic [31:0] E_HL_data,
   output logic        E_mdu_busy,
   output logic        E_mdu_start,
   output logic        E_mdu_stall
);

   logic [1:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [31:0]        r_hi_p;
   logic [31:0]        r_lo_p;
   logic               r_busy;

   logic [3:0]         w_op;
   logic               w_is_mul;
   logic               w_is_div;
   logic               w_idle;
   logic [31:0]        w_hi_nxt;
   logic [31:0]        w_lo_nxt;

   assign w_op   = E_mdu_valid ? E_mdu_op : c_op_none;
   assign w_idle = (r_state == c_st_idle);

`ifdef MDU_MADD_EN
   assign w_is_mul = (w_op == c_op_mult) || (w_op == c_op_multu) ||
                     (w_op == c_op_madd) || (w_op == c_op_maddu);
`else
   assign w_is_mul = (w_op == c_op_mult) || (w_op == c_op_multu);
`endif
   assign w_is_div = (w_op == c_op_div) || (w_op == c_op_divu);

   mdu_arith u_arith (
      .i_op     (w_op),
      .i_rs     (E_rs_data),
      .i_rt     (E_rt_data),
      .i_hi     (r_hi),
      .i_lo     (r_lo),
      .o_hi_nxt (w_hi_nxt),
      .o_lo_nxt (w_lo_nxt)
   );

   assign E_mdu_start = w_idle && (w_is_mul || w_is_div);
   assign E_mdu_busy  = r_busy;
   assign E_mdu_stall = E_mdu_start || r_busy;

   always_comb begin
      E_HL_data = 32'd0;
      if (w_op == c_op_mfhi)      E_HL_data = r_hi;
      else if (w_op == c_op_mflo) E_HL_data = r_lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_idle;
         r_cnt   <= '0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_hi_p  <= 32'd0;
         r_lo_p  <= 32'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_is_mul) begin
                  r_state <= c_st_mul;
                  r_cnt   <= c_cnt_w'(MULT_CYCLES);
                  r_hi_p  <= w_hi_nxt;
                  r_lo_p  <= w_lo_nxt;
                  r_busy  <= 1'b1;
               end else if (w_is_div) begin
                  r_state <= c_st_div;
                  r_cnt   <= c_cnt_w'(DIV_CYCLES);
                  r_hi_p  <= w_hi_nxt;
                  r_lo_p  <= w_lo_nxt;
                  r_busy  <= 1'b1;
               end else if (w_op == c_op_mthi) begin
                  r_hi <= E_rs_data;
               end else if (w_op == c_op_mtlo) begin
                  r_lo <= E_rs_data;
               end
            end
            // Ops presented here are ignored: the hazard unit must stall them.
            c_st_mul, c_st_div: begin
               if (r_cnt == c_cnt_w'(1)) begin
                  r_hi    <= r_hi_p;
                  r_lo    <= r_lo_p;
                  r_state <= c_st_idle;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - c_cnt_w'(1);
               end
            end
            default: begin
               r_state <= c_st_idle;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : e_mdu_ctrl
`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_e_mdu_ctrl
// Description : Directed self-checking testbench for e_mdu_ctrl.
// Config      : honours MDU_MADD_EN for the MADDU scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e_mdu_ctrl;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADDU = 4'd10;

   logic        clk;
   logic        reset;
   logic [3:0]  E_mdu_op;
   logic        E_mdu_valid;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic [31:0] E_HL_data;
   logic        E_mdu_busy;
   logic        E_mdu_start;
   logic        E_mdu_stall;

   int n_pass;
   int n_total;

   e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .E_mdu_op    (E_mdu_op),
      .E_mdu_valid (E_mdu_valid),
      .E_rs_data   (E_rs_data),
      .E_rt_data   (E_rt_data),
      .E_HL_data   (E_HL_data),
      .E_mdu_busy  (E_mdu_busy),
      .E_mdu_start (E_mdu_start),
      .E_mdu_stall (E_mdu_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // a few units later, well before the next edge.
   task automatic idle_inputs();
      E_mdu_op    = OP_NONE;
      E_mdu_valid = 1'b0;
      E_rs_data   = 32'd0;
      E_rt_data   = 32'd0;
   endtask

   // Read committed HI/LO through MFHI/MFLO within the current cycle.
   task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
      E_mdu_valid = 1'b1;
      E_mdu_op    = OP_MFHI;
      #1 hi = E_HL_data;
      E_mdu_op    = OP_MFLO;
      #1 lo = E_HL_data;
      idle_inputs();
   endtask

   // Present one op for one cycle, then count busy cycles (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic start_seen,
                         output logic stall_seen, output int busy_cnt);
      @(posedge clk); #1;
      E_mdu_op    = op;
      E_mdu_valid = 1'b1;
      E_rs_data   = a;
      E_rt_data   = b;
      #2;
      start_seen = E_mdu_start;
      stall_seen = E_mdu_stall;
      @(posedge clk); #1;
      idle_inputs();
      busy_cnt = 0;
      while (E_mdu_busy && busy_cnt < 40) begin
         busy_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      n_total++;
      if (E_mdu_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", E_mdu_busy);
      else n_pass++;
      n_total++;
      if (E_mdu_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", E_mdu_stall);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_hilo: got %h:%h expected 0:0", hi, lo);
      else n_pass++;
   endtask

   task automatic test_mult();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, st, sl, bc);
      n_total++;
      if (st !== 1'b1 || sl !== 1'b1) $display("FAIL mult_start: got start=%b stall=%b expected 1/1", st, sl);
      else n_pass++;
      n_total++;
      if (bc != 5) $display("FAIL mult_busy_cycles: got %0d expected 5", bc);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE)
         $display("FAIL mult_result: got %h:%h expected ffffffff:fffffffe", hi, lo);
      else n_pass++;
   endtask

   task automatic test_div();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      run_op(OP_DIVU, 32'd100, 32'd7, st, sl, bc);
      n_total++;
      if (bc != 10) $display("FAIL divu_busy_cycles: got %0d expected 10", bc);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'd2 || lo !== 32'd14) $display("FAIL divu_result: got %h:%h expected 2:e", hi, lo);
      else n_pass++;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, st, sl, bc);
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD)
         $display("FAIL div_signed_result: got %h:%h expected ffffffff:fffffffd", hi, lo);
      else n_pass++;
   endtask

   task automatic test_mthi_mflo();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      run_op(OP_MTHI, 32'h0000_1234, 32'd0, st, sl, bc);
      n_total++;
      if (st !== 1'b0 || sl !== 1'b0 || bc != 0)
         $display("FAIL mthi_no_busy: got start=%b stall=%b busy_cycles=%0d expected 0/0/0", st, sl, bc);
      else n_pass++;
      // MFHI in the cycle right after the MTHI edge
      E_mdu_valid = 1'b1;
      E_mdu_op    = OP_MFHI;
      #1;
      n_total++;
      if (E_HL_data !== 32'h0000_1234) $display("FAIL mfhi_after_mthi: got %h expected 00001234", E_HL_data);
      else n_pass++;
      E_mdu_op = OP_MTHI;
      #1;
      n_total++;
      if (E_HL_data !== 32'd0) $display("FAIL hl_data_non_mf: got %h expected 0", E_HL_data);
      else n_pass++;
      idle_inputs();
      run_op(OP_MTLO, 32'h0000_5678, 32'd0, st, sl, bc);
      // MTHI with valid low must not write
      @(posedge clk); #1;
      E_mdu_op    = OP_MTHI;
      E_mdu_valid = 1'b0;
      E_rs_data   = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      idle_inputs();
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
         $display("FAIL mtlo_and_invalid: got %h:%h expected 00001234:00005678", hi, lo);
      else n_pass++;
   endtask

   task automatic test_div_by_zero();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      run_op(OP_DIV, 32'd55, 32'd0, st, sl, bc);
      n_total++;
      if (bc != 10) $display("FAIL div0_busy_cycles: got %0d expected 10", bc);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678)
         $display("FAIL div0_hold: got %h:%h expected 00001234:00005678", hi, lo);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      @(posedge clk); #1;
      E_mdu_op    = OP_MULT;
      E_mdu_valid = 1'b1;
      E_rs_data   = 32'd5;
      E_rt_data   = 32'd6;
      @(posedge clk); #1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;   // asserted during busy cycle 3
      @(posedge clk); #1;
      reset = 1'b0;
      n_total++;
      if (E_mdu_busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", E_mdu_busy);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_mid_hilo: got %h:%h expected 0:0", hi, lo);
      else n_pass++;
      run_op(OP_MULTU, 32'd3, 32'd4, st, sl, bc);
      n_total++;
      if (bc != 5) $display("FAIL post_reset_busy: got %0d expected 5", bc);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'd0 || lo !== 32'd12) $display("FAIL post_reset_multu: got %h:%h expected 0:c", hi, lo);
      else n_pass++;
   endtask

   task automatic test_op_while_busy();
      int bc;
      logic start_bad;
      logic [31:0] hi, lo;
      start_bad = 1'b0;
      @(posedge clk); #1;
      E_mdu_op    = OP_DIVU;
      E_mdu_valid = 1'b1;
      E_rs_data   = 32'd100;
      E_rt_data   = 32'd7;
      @(posedge clk); #1;
      // Keep presenting MULT/MTHI while the divide is in flight
      bc = 0;
      while (E_mdu_busy && bc < 40) begin
         E_mdu_op    = (bc < 5) ? OP_MULT : OP_MTHI;
         E_mdu_valid = 1'b1;
         E_rs_data   = 32'd3;
         E_rt_data   = 32'd3;
         #2;
         if (E_mdu_start !== 1'b0) start_bad = 1'b1;
         bc++;
         @(posedge clk); #1;
      end
      idle_inputs();
      n_total++;
      if (start_bad !== 1'b0) $display("FAIL busy_start: got start=1 while busy expected 0");
      else n_pass++;
      n_total++;
      if (bc != 10) $display("FAIL busy_ignore_cycles: got %0d expected 10", bc);
      else n_pass++;
      read_hl(hi, lo);
      n_total++;
      if (hi !== 32'd2 || lo !== 32'd14) $display("FAIL busy_ignore_result: got %h:%h expected 2:e", hi, lo);
      else n_pass++;
   endtask

   task automatic test_maddu();
      logic st, sl;
      int bc;
      logic [31:0] hi, lo;
      run_op(OP_MTHI, 32'd0, 32'd0, st, sl, bc);
      run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, st, sl, bc);
      run_op(OP_MADDU, 32'd1, 32'd1, st, sl, bc);
      read_hl(hi, lo);
`ifdef MDU_MADD_EN
      n_total++;
      if (sl !== 1'b1 || bc != 5) $display("FAIL maddu_busy: got stall=%b busy_cycles=%0d expected 1/5", sl, bc);
      else n_pass++;
      n_total++;
      if (hi !== 32'd1 || lo !== 32'd0) $display("FAIL maddu_result: got %h:%h expected 1:0", hi, lo);
      else n_pass++;
`else
      n_total++;
      if (sl !== 1'b0 || st !== 1'b0 || bc != 0)
         $display("FAIL maddu_disabled_stall: got stall=%b start=%b busy_cycles=%0d expected 0/0/0", sl, st, bc);
      else n_pass++;
      n_total++;
      if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF)
         $display("FAIL maddu_disabled_hold: got %h:%h expected 0:ffffffff", hi, lo);
      else n_pass++;
`endif
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset   = 1'b1;
      idle_inputs();
      test_reset();
      test_mult();
      test_div();
      test_mthi_mflo();
      test_div_by_zero();
      test_reset_mid_op();
      test_op_while_busy();
      test_maddu();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_e_mdu_ctrl
`default_nettype wire
